// File: rtl/axis_cpu_loader_if.sv
// axis_cpu_loader_if: program stream, CPU command stream and CPU response stream
interface axis_cpu_loader_if;
  logic [31:0] prog_TDATA;
  logic        prog_TVALID;
  logic        prog_TREADY;
  logic        prog_TLAST;
  logic [31:0] cmd_out_TDATA;
  logic        cmd_out_TVALID;
  logic [31:0] rsp_in_TDATA;
  logic        rsp_in_TVALID;
  modport master (
    input  prog_TDATA, prog_TVALID, prog_TLAST, rsp_in_TDATA, rsp_in_TVALID,
    output prog_TREADY, cmd_out_TDATA, cmd_out_TVALID
  );
  modport slave (
    output prog_TDATA, prog_TVALID, prog_TLAST, rsp_in_TDATA, rsp_in_TVALID,
    input  prog_TREADY, cmd_out_TDATA, cmd_out_TVALID
  );
endinterface

// File: rtl/axis_cpu_loader.sv
// axis_cpu_loader: streams a program image into the CPU via acknowledged register writes
module axis_cpu_loader #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  axis_cpu_loader_if.master        bus,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [CODE_ADDR_WIDTH:0] inst_count
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST_CYC = TW'(ACK_TIMEOUT - 1);
  localparam logic [CODE_ADDR_WIDTH:0] MAXN = {1'b1, {CODE_ADDR_WIDTH{1'b0}}};
  typedef enum logic [3:0] {IDLE, SETHOLD, SETADDR, FETCH, SETINST, RELEASE, WAIT_ACK, DONE, ERR} state_t;
  state_t state, nxt, kind;
  logic ph, send, ack, tmo, full, last;
  logic [7:0] tag, rg;
  logic [TW-1:0] timer;
  logic [31:0] word, dat;
  logic unused;
  assign unused = ^bus.rsp_in_TDATA[15:0];
  // decode acks, build command beats and choose the next state
  always_comb begin
    send = state inside {SETHOLD, SETADDR, SETINST, RELEASE};
    ack = bus.rsp_in_TVALID && bus.rsp_in_TDATA[31:24] == 8'hAC && bus.rsp_in_TDATA[23:16] == tag;
    tmo = timer == TLAST_CYC;
    full = inst_count == MAXN;
    rg = state == SETADDR ? 8'h01 : state == SETINST ? 8'h02 : 8'h00;
    dat = state == SETHOLD ? 32'h1 : state == SETINST ? word : 32'h0;
    bus.cmd_out_TVALID = send;
    bus.cmd_out_TDATA = !send ? 32'h0 : ph ? dat : {8'hA5, tag, 8'h00, rg};
    bus.prog_TREADY = state == FETCH && !full;
    nxt = state;
    case (state)
      IDLE: nxt = start ? SETHOLD : IDLE;
      SETHOLD, SETADDR, SETINST, RELEASE: nxt = ph ? WAIT_ACK : state;
      FETCH: nxt = !bus.prog_TVALID ? FETCH : full ? ERR : SETINST;
      WAIT_ACK: nxt = ack ? (kind == SETHOLD ? SETADDR :
                             kind == SETADDR ? FETCH :
                             kind == SETINST ? (last ? RELEASE : FETCH) : DONE)
                          : tmo ? ERR : WAIT_ACK;
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // beat phase, ack timer, captured beat and the write awaiting its ack
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ph <= 1'b0;
      timer <= '0;
      kind <= IDLE;
      word <= '0;
      last <= 1'b0;
    end else begin
      ph <= send && !ph;
      timer <= state == WAIT_ACK ? timer + TW'(1) : '0;
      if (send) kind <= state;
      if (bus.prog_TVALID && bus.prog_TREADY) begin
        word <= bus.prog_TDATA;
        last <= bus.prog_TLAST;
      end
    end
  // tag sequencing and load status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tag <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'b00;
      inst_count <= '0;
    end else begin
      if (state == IDLE && start) begin
        busy <= 1'b1;
        done <= 1'b0;
        err <= 1'b0;
        err_code <= 2'b00;
        inst_count <= '0;
      end
      if (state == WAIT_ACK && ack) tag <= tag + 8'd1;
      if (state == WAIT_ACK && ack && kind == SETINST) inst_count <= inst_count + (CODE_ADDR_WIDTH + 1)'(1);
      if (state == WAIT_ACK && !ack && tmo) err_code <= 2'b01;
      if (state == FETCH && bus.prog_TVALID && full) err_code <= 2'b10;
      if (state == DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
      if (state == ERR) begin
        err <= 1'b1;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_axis_cpu_loader.sv
// tb_axis_cpu_loader: CPU/stream models with a write-sequence reference for axis_cpu_loader
module tb_axis_cpu_loader;
  localparam int CAW = 2;
  localparam int TMO = 4;
  localparam int MAXW = 1 << CAW;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, err;
  logic [1:0] err_code;
  logic [CAW:0] inst_count;
  axis_cpu_loader_if bus();
  axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .inst_count(inst_count)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [31:0] words [8];
  int n = 0, acc = 0;
  logic prog_en = 1'b0;
  int delay = 1;
  logic ack_en = 1'b1, junk = 1'b0, spur = 1'b0, hdr_next = 1'b1, pend = 1'b0, rdy_seen = 1'b0;
  int cnt = 0;
  logic [7:0] ctag = 8'h00, m_tag = 8'h00;
  logic [31:0] got [$];
  logic [31:0] exp_q [$];

  always @(posedge clk)
    if (start) acc <= 0;
    else if (bus.prog_TVALID && bus.prog_TREADY) acc <= acc + 1;

  always @(negedge clk) begin
    bus.prog_TVALID = prog_en && acc < n;
    bus.prog_TDATA = words[acc % 8];
    bus.prog_TLAST = acc == n - 1;
  end

  always @(negedge clk) begin
    bus.rsp_in_TVALID = 1'b0;
    bus.rsp_in_TDATA = 32'h0;
    if (bus.prog_TREADY) rdy_seen = 1'b1;
    if (rst) begin
      hdr_next = 1'b1;
      pend = 1'b0;
    end else begin
      if (pend) begin
        if (cnt == 0) begin
          if (ack_en) begin
            bus.rsp_in_TVALID = 1'b1;
            bus.rsp_in_TDATA = {8'hAC, ctag, 16'($urandom)};
          end
          pend = 1'b0;
        end else begin
          cnt--;
          if (junk) begin
            bus.rsp_in_TVALID = 1'b1;
            bus.rsp_in_TDATA = (cnt % 2 == 1) ? {8'hAC, ctag + 8'd1, 16'h0} : {8'hAB, ctag, 16'h0};
          end
        end
      end else if (spur) begin
        bus.rsp_in_TVALID = 1'b1;
        bus.rsp_in_TDATA = {8'hAC, ctag + 8'd1, 16'h0};
      end
      if (bus.cmd_out_TVALID) begin
        got.push_back(bus.cmd_out_TDATA);
        if (hdr_next) ctag = bus.cmd_out_TDATA[23:16];
        else begin
          pend = 1'b1;
          cnt = delay;
        end
        hdr_next = !hdr_next;
      end
    end
  end

  task automatic add_wr(input logic [7:0] r, input logic [31:0] d);
    exp_q.push_back({8'hA5, m_tag, 8'h00, r});
    exp_q.push_back(d);
    m_tag = m_tag + 8'd1;
  endtask

  task automatic start_load();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    while (busy === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
    end
  endtask

  task automatic cmp_seq(input string name);
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_len: got %0d beats, required %0d", name, got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_beat%0d: got %h, required %h", name, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic run_load(input string name, input int nw, input bit stall);
    int k, j;
    bit ovf;
    int ni;
    ovf = nw > MAXW;
    ni = ovf ? MAXW : nw;
    exp_q.delete();
    got.delete();
    add_wr(8'h00, 32'h1);
    add_wr(8'h01, 32'h0);
    for (int i = 0; i < ni; i++) add_wr(8'h02, words[i]);
    if (!ovf) add_wr(8'h00, 32'h0);
    n = nw;
    prog_en = !stall;
    start_load();
    checks++;
    if (bus.cmd_out_TVALID !== 1'b1 || bus.cmd_out_TDATA !== exp_q[0]) begin
      failures++;
      $display("FAIL %s_first_hdr: valid=%b data=%h, required 1 %h", name, bus.cmd_out_TVALID, bus.cmd_out_TDATA, exp_q[0]);
    end
    if (stall) begin
      j = 0;
      while (bus.prog_TREADY !== 1'b1 && j < 100) begin
        @(negedge clk);
        j++;
      end
      spur = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checks++;
        if (bus.cmd_out_TVALID !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
          failures++;
          $display("FAIL %s_stall%0d: cmd_valid=%b busy=%b err=%b, required 0 1 0", name, c, bus.cmd_out_TVALID, busy, err);
        end
      end
      spur = 1'b0;
      prog_en = 1'b1;
    end
    wait_idle(k);
    cmp_seq(name);
    checks++;
    if (done !== !ovf || err !== ovf || err_code !== (ovf ? 2'b10 : 2'b00) || inst_count !== (CAW+1)'(ni)) begin
      failures++;
      $display("FAIL %s_status: done=%b err=%b code=%b count=%0d, required %b %b %b %0d",
               name, done, err, err_code, inst_count, !ovf, ovf, ovf ? 2'b10 : 2'b00, ni);
    end
    if (ovf) begin
      checks++;
      if (acc !== MAXW) begin
        failures++;
        $display("FAIL %s_accepted: %0d beats taken, required %0d", name, acc, MAXW);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 0 || done !== 0 || err !== 0 || err_code !== 0 || inst_count !== 0 ||
        bus.cmd_out_TVALID !== 0 || bus.cmd_out_TDATA !== 0 || bus.prog_TREADY !== 0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b err=%b code=%b count=%0d cv=%b cd=%h rdy=%b, required all 0",
               busy, done, err, err_code, inst_count, bus.cmd_out_TVALID, bus.cmd_out_TDATA, bus.prog_TREADY);
    end
    rst = 1'b0;
    m_tag = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_basic();
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    delay = 1;
    run_load("basic", 3, 1'b0);
    checks++;
    if (got.size() == 12 && (got[10] !== 32'hA5050000 || got[2] !== 32'hA5010001)) begin
      failures++;
      $display("FAIL basic_plan: beat2=%h beat10=%h, required A5010001 A5050000", got[2], got[10]);
    end
  endtask

  task automatic test_timeout();
    int k;
    words[0] = $urandom;
    ack_en = 1'b0;
    rdy_seen = 1'b0;
    exp_q.delete();
    got.delete();
    exp_q.push_back({8'hA5, m_tag, 8'h00, 8'h00});
    exp_q.push_back(32'h1);
    n = 1;
    prog_en = 1'b1;
    start_load();
    wait_idle(k);
    cmp_seq("timeout");
    checks++;
    if (err !== 1 || err_code !== 2'b01 || done !== 0 || busy !== 0 || rdy_seen !== 0) begin
      failures++;
      $display("FAIL timeout_status: err=%b code=%b done=%b busy=%b ready_seen=%b, required 1 01 0 0 0",
               err, err_code, done, busy, rdy_seen);
    end
    checks++;
    if (k != TMO + 3) begin
      failures++;
      $display("FAIL timeout_latency: idle after %0d cycles, required %0d", k, TMO + 3);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    delay = $urandom_range(0, TMO - 1);
    run_load("overflow", 5, 1'b0);
  endtask

  task automatic test_junk();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    junk = 1'b1;
    delay = TMO - 1;
    run_load("junk", 3, 1'b0);
    junk = 1'b0;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) words[i] = $urandom;
    delay = 1;
    run_load("stall", 2, 1'b1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 8; i++) words[i] = $urandom;
      delay = $urandom_range(0, TMO - 1);
      junk = $urandom_range(0, 1);
      run_load("random", $urandom_range(1, MAXW + 1), $urandom_range(0, 1) == 1);
      junk = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int j;
    words[0] = $urandom;
    n = 1;
    prog_en = 1'b1;
    delay = 1;
    start_load();
    j = 0;
    while (!(bus.cmd_out_TVALID === 1'b1 && bus.cmd_out_TDATA === 32'h1) && j < 20) begin
      @(negedge clk);
      j++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.cmd_out_TVALID !== 0 || bus.cmd_out_TDATA !== 0 || busy !== 0 || done !== 0 || err !== 0 ||
        err_code !== 0 || inst_count !== 0 || bus.prog_TREADY !== 0) begin
      failures++;
      $display("FAIL reset_mid: cv=%b cd=%h busy=%b done=%b err=%b code=%b count=%0d rdy=%b, required all 0",
               bus.cmd_out_TVALID, bus.cmd_out_TDATA, busy, done, err, err_code, inst_count, bus.prog_TREADY);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_tag = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    run_load("after_reset", 3, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_junk();
    test_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axis_cpu_loader.md
Name: axis_cpu_loader

Overview:
Host-side initiator for the axis_cpu programming interface. It takes a program image from an AXI-Stream, one 32-bit instruction per beat with TLAST on the final beat, and drives the CPU's no-backpressure command input as register-write transactions. After each write it waits for a tagged acknowledgement on the CPU's command-output port. The CPU is held in reset for the whole load and released at the end.

Parameters:
CODE_ADDR_WIDTH, 10, CPU instruction-memory address width; the maximum program length is 2**CODE_ADDR_WIDTH words.
ACK_TIMEOUT, 255, maximum number of cycles spent in WAIT_ACK before an error is raised (must be ≥1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a load when idle
prog_TDATA  in  32  instruction word
prog_TVALID  in  1  program beat valid
prog_TREADY  out  1  program beat accepted
prog_TLAST  in  1  last instruction of the program
cmd_out_TDATA  out  32  command word, connects to CPU cmd_in_TDATA
cmd_out_TVALID  out  1  command word valid; no backpressure
rsp_in_TDATA  in  32  response word, connects to CPU cmd_out_TDATA
rsp_in_TVALID  in  1  response valid
busy  out  1  load in progress
done  out  1  last load completed successfully (sticky)
err  out  1  last load failed (sticky)
err_code  out  2  01 = ack timeout, 10 = program overflow
inst_count  out  CODE_ADDR_WIDTH+1  instructions acknowledged in the current or last load

Behaviour:
- Async reset: state IDLE. All outputs are 0, tag is 0, timer is 0.
- Write transaction = 2 consecutive beats, cmd_out_TVALID high on both:
  - HDR beat: {8'hA5, tag[7:0], 8'h00, reg[7:0]}
  - DAT beat: data[31:0]
- Registers: 0x00 HOLD (1 = hold CPU in reset, 0 = release), 0x01 ADDR, 0x02 INST (CPU auto-increments ADDR).
- Ack: rsp_in_TVALID high and rsp_in_TDATA[31:24]==8'hAC and [23:16]==current tag. Bits [15:0] are ignored. Non-matching or unexpected responses are ignored in every state.
- tag increments by 1 (wraps at 8 bits) on each accepted ack. It is not cleared by start.
- Sequence per load: HOLD=1, ADDR=0, then INST once per program beat, then HOLD=0.
- States:
  - IDLE: on start, clear done, err, err_code and inst_count, set busy, go to state SETHOLD.
  - SETHOLD / SETADDR: issue the write (HDR, DAT), then go to WAIT_ACK.
  - FETCH: prog_TREADY is high only in this state.
    - On prog_TVALID, capture the word and its TLAST, then issue an INST write.
    - If inst_count == 2**CODE_ADDR_WIDTH when a beat is valid: do not accept it; set err_code=10 and go to ERR.
  - WAIT_ACK: the timer counts from 0 starting the cycle after DAT.
    - Ack in the same cycle the timer reaches ACK_TIMEOUT-1 counts as success.
    - No ack by that cycle: set err_code=01 and go to ERR.
    - After an ack, the next state depends on the write just acknowledged:
      - HOLD=1 → SETADDR
      - ADDR → FETCH
      - INST → increment inst_count; go to RELEASE if the captured TLAST was 1, else FETCH
      - HOLD=0 → DONE
  - RELEASE: issue HOLD=0, then go to WAIT_ACK.
  - DONE: set done, clear busy, go to IDLE.
  - ERR: set err, clear busy, go to IDLE. The CPU stays held; no release write is sent.
- Latency: from the start pulse, the HOLD HDR beat appears on cycle +1. Each write occupies 2 beats plus ≥1 WAIT_ACK cycle.
- start while busy is ignored. start and ack in the same cycle: the ack is handled and start is ignored.
- Reset mid-load: cmd_out_TVALID falls immediately and any partial transaction is abandoned.

Test Plan:
- 3-word program (0x11111111, 0x22222222, 0x33333333+TLAST), CPU model acks on cycle 2 of WAIT_ACK → cmd_out sequence:
  - A5000000, 00000001
  - A5010001, 00000000
  - A5020002, 11111111
  - A5030002, 22222222
  - A5040002, 33333333
  - A5050000, 00000000
  - Result: done=1, inst_count=3, tag=6.
- Model never acks the first HDR, ACK_TIMEOUT=4 → err=1, err_code=01 after 4 WAIT_ACK cycles, busy=0, prog_TREADY never asserted.
- CODE_ADDR_WIDTH=2 with a 5-word program → 4 INST writes acked, 5th beat not accepted, err_code=10, inst_count=4, no HOLD=0 write issued.
- Responses with wrong tag or with 8'hAB header during WAIT_ACK → ignored. A later correct ack advances the load; inst_count matches the number of correct acks.
- prog_TVALID low for 10 cycles in FETCH → cmd_out_TVALID stays 0 and no timeout occurs; the load resumes when the beat arrives.
- rst asserted during a DAT beat → cmd_out_TVALID=0 asynchronously, all outputs 0. A fresh start then gives a correct sequence beginning with tag 00.
